serial_in: RTL and testbench

SERIAL_IN -- requirements
Module: serial_in

---
 rtl/serial_pkg.sv | 11 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/serial_in.sv | 113 +++++++++++
 tb/tb_serial_in.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and types for the serial_in receiver.
//   DEPTH_DEF   - default receive FIFO depth in bytes
//   TIMEOUT_DEF - default idle clk cycles before a partial byte is aborted
//   BCNT_W      - width of the received-bit counter
//   byte_t      - one received byte
package serial_pkg;
   localparam int DEPTH_DEF   = 8;
   localparam int TIMEOUT_DEF = 4096;
   localparam int BCNT_W      = 4;
   typedef logic [7:0] byte_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through byte FIFO.
//   clk, rst_n  - clock, async active-low reset (pointers only)
//   push, wdata - write request and data; dropped when full unless popping
//   pop         - pop request; ignored when empty
//   rdata       - head byte, forced to 0 while empty
//   full, empty - occupancy flags
//   count       - bytes held, 0..DEPTH
module sync_fifo
   import serial_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  byte_t                    wdata,
   input  logic                     pop,
   output byte_t                    rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr, rd_ptr;
   byte_t       mem [DEPTH];
   logic        pop_ok, push_ok;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + ONE;
      end
   end

   // Storage holds no meaningful state across reset, so it is left unreset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/serial_in.sv
// serial_in: clocked-serial byte receiver with receive FIFO.
//   clk, rst_n     - system clock, async active-low reset
//   sclk, sdata    - serial bit clock (idles low) and data, asynchronous to clk;
//                    data is sampled on sclk falling edges, LSB first
//   rd_en          - pop the FIFO head
//   err_clr        - clear the sticky ovf / frm_err flags
//   rd_data        - FIFO head byte (first-word-fall-through)
//   empty, count   - FIFO occupancy
//   ovf            - sticky: a byte was dropped because the FIFO was full
//   frm_err        - sticky: a partial byte was aborted by the idle timeout
module serial_in
   import serial_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sclk,
   input  logic                     sdata,
   input  logic                     rd_en,
   input  logic                     err_clr,
   output byte_t                    rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     frm_err
);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0]     IDLE_MAX = IW'(TIMEOUT);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(7);
   localparam logic [BCNT_W-1:0] BONE     = BCNT_W'(1);
   localparam logic [IW-1:0]     IONE     = IW'(1);

   logic              sclk_m, sclk_s, sclk_d;
   logic              sdata_m, sdata_s;
   logic [IW-1:0]     idle_cnt;
   logic [BCNT_W-1:0] bit_cnt;
   byte_t             shreg;
   byte_t             push_byte;
   logic              push_q;
   logic              fall, any_edge, byte_done, abort;
   logic              fifo_full, ovf_set;

   assign fall      = sclk_d & ~sclk_s;
   assign any_edge  = sclk_d ^ sclk_s;
   assign byte_done = fall && (bit_cnt == LAST_BIT);
   // An edge this cycle means the line is alive, so it overrides the timeout.
   assign abort     = ~any_edge && (idle_cnt == IDLE_MAX) && (bit_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_m    <= 1'b0;
         sclk_s    <= 1'b0;
         sclk_d    <= 1'b0;
         sdata_m   <= 1'b0;
         sdata_s   <= 1'b0;
         idle_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         push_byte <= '0;
         push_q    <= 1'b0;
      end else begin
         sclk_m  <= sclk;
         sclk_s  <= sclk_m;
         sclk_d  <= sclk_s;
         sdata_m <= sdata;
         sdata_s <= sdata_m;

         if (any_edge)                  idle_cnt <= '0;
         else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IONE;

         // Completed byte is registered and pushed on the following edge.
         push_q <= byte_done;
         if (byte_done) begin
            push_byte <= {sdata_s, shreg[7:1]};
            shreg     <= '0;
            bit_cnt   <= '0;
         end else if (fall) begin
            shreg   <= {sdata_s, shreg[7:1]};
            bit_cnt <= bit_cnt + BONE;
         end else if (abort) begin
            shreg   <= '0;
            bit_cnt <= '0;
         end
      end
   end

   // When full, empty is 0, so a pop in the same cycle always makes room.
   assign ovf_set = push_q & fifo_full & ~rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf     <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         ovf     <= ovf_set | (ovf & ~err_clr);
         frm_err <= abort   | (frm_err & ~err_clr);
      end
   end

   sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_q),
      .wdata (push_byte),
      .pop   (rd_en),
      .rdata (rd_data),
      .full  (fifo_full),
      .empty (empty),
      .count (count)
   );
endmodule

// File: tb/tb_serial_in.sv
module tb_serial_in;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n, sclk, sdata, rd_en, err_clr;
   logic [7:0] rd_data;
   logic       empty, ovf, frm_err;
   logic [3:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: expected FIFO contents and sticky flags.
   logic [7:0] exp_q[$];
   logic       exp_ovf = 1'b0;
   logic       exp_frm = 1'b0;

   serial_in #(.DEPTH(DEPTH), .TIMEOUT(4096)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sclk    (sclk),
      .sdata   (sdata),
      .rd_en   (rd_en),
      .err_clr (err_clr),
      .rd_data (rd_data),
      .empty   (empty),
      .count   (count),
      .ovf     (ovf),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: every accepted pop is compared against the model head.
   always @(negedge clk) begin
      if (rst_n && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("pop_data", int'(rd_data), int'(e));
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sclk_bit(input logic v, input int half);
      sdata = v;
      sclk  = 1'b1;
      wait_clk(half);
      sclk  = 1'b0;
      wait_clk(half);
   endtask

   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovf = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int half);
      for (int i = 0; i < 8; i++) sclk_bit(b[i], half);
      model_push(b);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      wait_clk(1);
      rd_en = 1'b0;
      wait_clk(1);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      exp_ovf = 1'b0;
      exp_frm = 1'b0;
      wait_clk(1);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_count"}, int'(count), exp_q.size());
      check({tag, "_empty"}, int'(empty), int'(exp_q.size() == 0));
      check({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
      check({tag, "_frm"}, int'(frm_err), int'(exp_frm));
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] a5;
      int         lat;
      rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      wait_clk(3);
      check("reset_rd_data", int'(rd_data), 0);
      check_state("reset");
      rst_n = 1'b1;
      wait_clk(4);

      // Pop while empty is ignored.
      pop();
      check_state("pop_empty");

      // 0xA5 at 2048 clk per bit, measuring push latency from the 8th fall.
      a5 = 8'hA5;
      for (int i = 0; i < 7; i++) sclk_bit(a5[i], 1024);
      sdata = a5[7];
      sclk  = 1'b1;
      wait_clk(1024);
      sclk  = 1'b0;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         wait_clk(1);
         if (!empty) begin lat = i; break; end
      end
      n_tests++;
      if (lat == 0 || lat > 4) begin
         n_fail++;
         $display("FAIL a5_latency: got %0d clk expected 1..4 clk", lat);
      end
      model_push(a5);
      wait_clk(1024);
      check("a5_rd_data", int'(rd_data), 8'hA5);
      check_state("a5");
      pop();
      check_state("a5_popped");

      // Four bytes in order.
      send_byte(8'h01, 8);
      send_byte(8'h80, 8);
      send_byte(8'hFF, 8);
      send_byte(8'h00, 8);
      check_state("four");
      repeat (4) pop();
      check_state("four_drained");

      // Nine bytes into an 8-deep FIFO: last one dropped, ovf set.
      for (int i = 0; i < 9; i++) send_byte(8'($urandom), 8);
      check_state("overflow");
      clear_err();
      check_state("ovf_cleared");
      repeat (DEPTH) pop();
      check_state("ovf_drained");

      // Full FIFO, 8th fall of a new byte coincides with a pop.
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 8);
      check_state("full");
      b = 8'($urandom);
      for (int i = 0; i < 7; i++) sclk_bit(b[i], 8);
      sdata = b[7];
      sclk  = 1'b1;
      wait_clk(8);
      sclk  = 1'b0;
      wait_clk(3);
      rd_en = 1'b1;
      wait_clk(1);
      rd_en = 1'b0;
      wait_clk(4);
      model_push(b);
      check_state("push_pop_full");
      repeat (DEPTH) pop();
      check_state("push_pop_drained");

      // Partial byte aborted by idle timeout; held byte untouched.
      send_byte(8'($urandom), 8);
      b = 8'h07;
      for (int i = 0; i < 3; i++) sclk_bit(b[i], 8);
      wait_clk(5000);
      exp_frm = 1'b1;
      check_state("timeout");
      clear_err();
      check_state("frm_cleared");
      send_byte(8'h3C, 8);
      check_state("after_timeout");
      repeat (2) pop();
      check_state("timeout_drained");

      // Reset mid-byte discards the partial byte.
      b = 8'h1F;
      for (int i = 0; i < 5; i++) sclk_bit(b[i], 8);
      rst_n = 1'b0;
      wait_clk(2);
      exp_q.delete();
      check_state("mid_reset");
      rst_n = 1'b1;
      wait_clk(3);
      send_byte(8'h5A, 8);
      check_state("after_reset");
      pop();
      check_state("after_reset_drained");

      // Random traffic with random bit rates and interleaved pops.
      for (int k = 0; k < 16; k++) begin
         if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) pop();
         else send_byte(8'($urandom), $urandom_range(5, 30));
         check_state("random");
         if (exp_ovf) clear_err();
      end
      while (exp_q.size() > 0) pop();
      check_state("random_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
